// File: rtl/ysyx_23060096_wb_arbiter.sv
// Write-back arbiter: grants one of EXU/LSU per cycle into a one-cycle
// write stage driving the register file, with decode-stage forwarding.
module ysyx_23060096_wb_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] fwd_ra,
    input  logic [ADDR_WIDTH-1:0] fwd_rb,
    output logic                  fwd_a_hit,
    output logic                  fwd_b_hit,
    output logic [DATA_WIDTH-1:0] fwd_a_data,
    output logic [DATA_WIDTH-1:0] fwd_b_data,
    output logic                  commit
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    logic                  force_exu;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // LSU wins ties unless the EXU has lost LIMIT times in a row
    assign force_exu = (starve_cnt == LIMIT);
    assign exu_ready = rstn && exu_valid && (!lsu_valid || force_exu);
    assign lsu_ready = rstn && lsu_valid && !(exu_valid && force_exu);

    assign accept   = exu_ready || lsu_ready;
    assign sel_rd   = exu_ready ? exu_rd : lsu_rd;
    assign sel_data = exu_ready ? exu_data : lsu_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= 4'd0;
        end else if (exu_valid && lsu_ready) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            commit   <= 1'b0;
        end else if (accept) begin
            rf_wen   <= (sel_rd != '0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
            commit   <= 1'b1;
        end else begin
            rf_wen   <= 1'b0;
            commit   <= 1'b0;
        end
    end

    assign fwd_a_hit  = rf_wen && (fwd_ra == rf_waddr);
    assign fwd_b_hit  = rf_wen && (fwd_rb == rf_waddr);
    assign fwd_a_data = fwd_a_hit ? rf_wdata : '0;
    assign fwd_b_data = fwd_b_hit ? rf_wdata : '0;

endmodule

// File: tb/tb_ysyx_23060096_wb_arbiter.sv
// Bench for the write-back arbiter: directed cases with literal
// expectations plus random traffic checked against a reference model.
module tb_ysyx_23060096_wb_arbiter;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          exu_valid, exu_ready;
    logic [AW-1:0] exu_rd;
    logic [DW-1:0] exu_data;
    logic          lsu_valid, lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] fwd_ra, fwd_rb;
    logic          fwd_a_hit, fwd_b_hit;
    logic [DW-1:0] fwd_a_data, fwd_b_data;
    logic          commit;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060096_wb_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rstn(rstn),
        .exu_valid(exu_valid), .exu_ready(exu_ready),
        .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_ra(fwd_ra), .fwd_rb(fwd_rb),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .commit(commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: state of the write stage as the spec describes it
    logic          m_wen, m_commit;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_losses;
    int            m_wait;
    logic          m_acc_e, m_acc_l;

    initial begin
        m_wen = 0; m_commit = 0; m_waddr = '0; m_wdata = '0;
        m_losses = 0; m_wait = 0; m_acc_e = 0; m_acc_l = 0;
    end

    always @(negedge clk) begin
        logic er, lr;
        logic [AW-1:0] rd;
        if (!rstn) begin
            m_wen = 0; m_commit = 0; m_waddr = '0; m_wdata = '0;
            m_losses = 0; m_wait = 0;
        end
        er = 0;
        lr = 0;
        if (rstn) begin
            if (exu_valid && lsu_valid) begin
                er = (m_losses == LIM);
                lr = !er;
            end else begin
                er = exu_valid;
                lr = lsu_valid;
            end
        end
        chk("m_exu_ready", exu_ready, er);
        chk("m_lsu_ready", lsu_ready, lr);
        chk("m_rf_wen", rf_wen, m_wen);
        chk("m_rf_waddr", rf_waddr, m_waddr);
        chk("m_rf_wdata", rf_wdata, m_wdata);
        chk("m_commit", commit, m_commit);
        chk("m_fwd_a_hit", fwd_a_hit, m_wen && fwd_ra == m_waddr);
        chk("m_fwd_b_hit", fwd_b_hit, m_wen && fwd_rb == m_waddr);
        chk("m_fwd_a_data", fwd_a_data,
            (m_wen && fwd_ra == m_waddr) ? m_wdata : '0);
        chk("m_fwd_b_data", fwd_b_data,
            (m_wen && fwd_rb == m_waddr) ? m_wdata : '0);
        if (rstn) begin
            if (er) begin
                chk("starve_bound", 64'(m_wait <= LIM), 64'd1);
                m_wait = 0;
            end else if (exu_valid) begin
                m_wait++;
            end else begin
                m_wait = 0;
            end
            if (er || lr) begin
                rd = er ? exu_rd : lsu_rd;
                m_waddr  = rd;
                m_wdata  = er ? exu_data : lsu_data;
                m_wen    = (rd != 0);
                m_commit = 1;
            end else begin
                m_wen = 0;
                m_commit = 0;
            end
            if (exu_valid && lr) begin
                if (m_losses < LIM) m_losses++;
            end else begin
                m_losses = 0;
            end
        end
        m_acc_e = er;
        m_acc_l = lr;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        exu_valid = 0;
        lsu_valid = 0;
    endtask

    initial begin
        int acc, cmt;
        rstn = 0;
        idle();
        exu_rd = '0; exu_data = '0; lsu_rd = '0; lsu_data = '0;
        fwd_ra = '0; fwd_rb = '0;

        @(negedge clk);
        chk("rst_rf_wen", rf_wen, 0);
        chk("rst_commit", commit, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        cyc();
        rstn = 1;
        cyc();

        // single EXU result
        exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_exu_ready", exu_ready, 1);
        cyc();
        idle();
        @(negedge clk);
        chk("single_wen", rf_wen, 1);
        chk("single_waddr", rf_waddr, 5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        chk("single_commit", commit, 1);
        cyc();
        @(negedge clk);
        chk("single_wen_off", rf_wen, 0);
        chk("single_commit_off", commit, 0);

        // x0 suppression via LSU
        cyc();
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h1234;
        cyc();
        idle();
        fwd_ra = 0;
        @(negedge clk);
        chk("x0_commit", commit, 1);
        chk("x0_wen", rf_wen, 0);
        chk("x0_fwd_hit", fwd_a_hit, 0);
        chk("x0_fwd_data", fwd_a_data, 0);

        // back-to-back to the same register
        cyc();
        exu_valid = 1; exu_rd = 3; exu_data = 1;
        fwd_ra = 3;
        cyc();
        exu_valid = 0;
        lsu_valid = 1; lsu_rd = 3; lsu_data = 2;
        @(negedge clk);
        chk("b2b_wdata1", rf_wdata, 1);
        chk("b2b_wen1", rf_wen, 1);
        chk("b2b_fwd1", fwd_a_data, 1);
        cyc();
        idle();
        @(negedge clk);
        chk("b2b_wdata2", rf_wdata, 2);
        chk("b2b_wen2", rf_wen, 1);
        chk("b2b_fwd2_hit", fwd_a_hit, 1);
        chk("b2b_fwd2", fwd_a_data, 2);

        // B-port forwarding
        cyc();
        exu_valid = 1; exu_rd = 7; exu_data = 32'hA5A5A5A5;
        fwd_ra = 6; fwd_rb = 7;
        cyc();
        idle();
        @(negedge clk);
        chk("fwdb_a_hit", fwd_a_hit, 0);
        chk("fwdb_b_hit", fwd_b_hit, 1);
        chk("fwdb_b_data", fwd_b_data, 32'hA5A5A5A5);
        cyc();

        // starvation: both valid for 10 cycles
        acc = 0;
        cmt = 0;
        exu_valid = 1; exu_rd = 10; exu_data = 32'h100;
        lsu_valid = 1; lsu_rd = 11; lsu_data = 32'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("starve_lsu_%0d", i), lsu_ready, (i % 5) != 4);
            chk($sformatf("starve_exu_%0d", i), exu_ready, (i % 5) == 4);
            if (exu_ready || lsu_ready) acc++;
            if (commit) cmt++;
            cyc();
            if ((i % 5) == 4) exu_data = exu_data + 1;
            else lsu_data = lsu_data + 1;
        end
        idle();
        @(negedge clk);
        if (commit) cmt++;
        chk("starve_accepts", 64'(acc), 10);
        chk("starve_commits", 64'(cmt), 64'(acc));
        cyc();

        // reset while the write stage is occupied
        exu_valid = 1; exu_rd = 9; exu_data = 32'h55;
        cyc();
        exu_valid = 0;
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h66;
        #1;
        chk("rst_mid_pre_wen", rf_wen, 1);
        rstn = 0;
        #1;
        chk("rst_mid_wen", rf_wen, 0);
        chk("rst_mid_commit", commit, 0);
        chk("rst_mid_waddr", rf_waddr, 0);
        chk("rst_mid_lsu_ready", lsu_ready, 0);
        chk("rst_mid_exu_ready", exu_ready, 0);
        cyc();
        idle();
        rstn = 1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rel_wen", rf_wen, 0);
            chk("rst_rel_commit", commit, 0);
            cyc();
        end

        // random traffic, holding each request until the model accepts it
        for (int i = 0; i < 600; i++) begin
            if (!exu_valid || m_acc_e) begin
                exu_valid = ($urandom_range(0, 99) < 60);
                exu_rd    = AW'($urandom_range(0, 31));
                exu_data  = $urandom;
            end
            if (!lsu_valid || m_acc_l) begin
                lsu_valid = ($urandom_range(0, 99) < 60);
                lsu_rd    = AW'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            fwd_ra = $urandom_range(0, 1) ? rf_waddr : AW'($urandom_range(0, 31));
            fwd_rb = $urandom_range(0, 1) ? rf_waddr : AW'($urandom_range(0, 31));
            if (i == 300) rstn = 0;
            if (i == 302) rstn = 1;
            cyc();
        end
        idle();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
